// File: rtl/vxe_axi_switch_mp_pkg.sv
// -----------------------------------------------------------------------------
// vxe_axi_switch_pkg
//   Shared definitions for the multi-client AXI switch: field offsets and
//   widths of the client request/response words and of the BIU transaction
//   ID, response codes, and packed views of the request words.
//   No ports (package).
// -----------------------------------------------------------------------------
package vxe_axi_switch_pkg;

  // Client index carried in the upper bits of every BIU transaction ID.
  localparam int CLI_W        = 3;
  localparam int TXN_W        = 3;
  localparam int ADDR_W       = 40;
  localparam int DATA_W       = 64;
  localparam int STRB_W       = 8;

  // Request address word: {wr, txnid, addr}
  localparam int RQA_W        = 44;
  localparam int RQA_ADDR_LSB = 0;
  localparam int RQA_TXN_LSB  = 40;
  localparam int RQA_WR_BIT   = 43;

  // Request data word: {strb, data}
  localparam int RQD_W        = 72;
  localparam int RQD_DATA_LSB = 0;
  localparam int RQD_STRB_LSB = 64;

  // Response status word: {wr, resp, 3'b000, txnid}
  localparam int RSS_W        = 9;
  localparam int RSS_TXN_LSB  = 0;
  localparam int RSS_RESP_LSB = 6;
  localparam int RSS_WR_BIT   = 8;

  // BIU transaction ID: {client, txnid}
  localparam int CID_W        = CLI_W + TXN_W;
  localparam int CID_TXN_LSB  = 0;
  localparam int CID_CLI_LSB  = TXN_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic              wr;
    logic [TXN_W-1:0]  txnid;
    logic [ADDR_W-1:0] addr;
  } rqa_t;

  typedef struct packed {
    logic [STRB_W-1:0] strb;
    logic [DATA_W-1:0] data;
  } rqd_t;

  function automatic logic [RSS_W-1:0] make_rss(input logic             wr,
                                                input logic [1:0]       resp,
                                                input logic [TXN_W-1:0] txnid);
    return {wr, resp, 3'b000, txnid};
  endfunction

endpackage

// File: rtl/vxe_axi_switch_mp_if.sv
// -----------------------------------------------------------------------------
// vxe_axi_switch_mp_if
//   Bundle of the switch <-> BIU signals.
//   master : switch side  (drives aw*/ar* requests and b/r ready)
//   slave  : BIU side     (drives pops and b/r responses)
// -----------------------------------------------------------------------------
interface vxe_axi_switch_mp_if;
  import vxe_axi_switch_pkg::*;

  logic [CID_W-1:0]  awcid;
  logic [ADDR_W-1:0] awaddr;
  logic [DATA_W-1:0] awdata;
  logic [STRB_W-1:0] awstrb;
  logic              awvalid;
  logic              awpop;

  logic [CID_W-1:0]  arcid;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arpop;

  logic [CID_W-1:0]  bcid;
  logic [1:0]        bresp;
  logic              bpush;
  logic              bready;

  logic [CID_W-1:0]  rcid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rpush;
  logic              rready;

  modport master (
    output awcid, awaddr, awdata, awstrb, awvalid, input awpop,
    output arcid, araddr, arvalid,                 input arpop,
    input  bcid, bresp, bpush,                     output bready,
    input  rcid, rdata, rresp, rpush,              output rready
  );

  modport slave (
    input  awcid, awaddr, awdata, awstrb, awvalid, output awpop,
    input  arcid, araddr, arvalid,                 output arpop,
    output bcid, bresp, bpush,                     input  bready,
    output rcid, rdata, rresp, rpush,              input  rready
  );
endinterface

// File: rtl/vxe_axi_switch_rr_arb.sv
// -----------------------------------------------------------------------------
// vxe_axi_switch_rr_arb
//   Combinational round-robin arbiter. The search for a requester starts at
//   rr and wraps; the first requester found is granted.
//   req       in  N       request vector
//   rr        in  PTR_W   search start pointer (< N)
//   grant     out N       one-hot grant
//   grant_idx out PTR_W   index of the granted requester
//   grant_vld out 1       any grant this cycle
// -----------------------------------------------------------------------------
module vxe_axi_switch_rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_vld
);

  int               idx;
  logic [PTR_W-1:0] idx_p;

  always_comb begin
    // NOTE: every output gets a default before the search so that no path
    // through the loop leaves a value unassigned, which would infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    idx_p     = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(rr) + off;
      if (idx >= N) idx = idx - N;
      idx_p = PTR_W'(idx);
      if (!grant_vld && req[idx_p]) begin
        grant_vld    = 1'b1;
        grant[idx_p] = 1'b1;
        grant_idx    = idx_p;
      end
    end
  end

endmodule

// File: rtl/vxe_axi_switch_mp.sv
// -----------------------------------------------------------------------------
// vxe_axi_switch_mp
//   Multi-client AXI switch between NCLIENTS memory-hub clients and the BIU.
//   Client requests are arbitrated round-robin onto one-entry AW/AR slots;
//   the client index is placed in cid[5:3]. B/R responses land in one-entry
//   slots and are delivered to the client named by cid[5:3].
//
//   Optional feature macro: VXE_AXI_SWITCH_OUTST_LIMIT_EN
//     defined   : per-client outstanding counters gate eligibility (MAX_OUTST)
//     undefined : no counters, MAX_OUTST unused
//
//   Ports
//     clk, rst               clock, synchronous active-high reset
//     i_m_rqa_vld/i_m_rqa    per-client request address {wr,txnid,addr}
//     o_m_rqa_rd             request address consumed (grant cycle)
//     i_m_rqd_vld/i_m_rqd    per-client write data {strb,data}
//     o_m_rqd_rd             write data consumed (grant cycle, writes)
//     i_m_rss_rdy            client status FIFO has room
//     o_m_rss/o_m_rss_wr     status word {wr,resp,000,txnid} and strobe
//     i_m_rsd_rdy            client read-data FIFO has room
//     o_m_rsd/o_m_rsd_wr     read data and strobe
//     biu                    BIU bus (master side)
// -----------------------------------------------------------------------------
module vxe_axi_switch_mp
  import vxe_axi_switch_pkg::*;
#(
  parameter int NCLIENTS  = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCLIENTS-1:0]       i_m_rqa_vld,
  input  logic [RQA_W*NCLIENTS-1:0] i_m_rqa,
  output logic [NCLIENTS-1:0]       o_m_rqa_rd,
  input  logic [NCLIENTS-1:0]       i_m_rqd_vld,
  input  logic [RQD_W*NCLIENTS-1:0] i_m_rqd,
  output logic [NCLIENTS-1:0]       o_m_rqd_rd,
  input  logic [NCLIENTS-1:0]       i_m_rss_rdy,
  output logic [RSS_W*NCLIENTS-1:0] o_m_rss,
  output logic [NCLIENTS-1:0]       o_m_rss_wr,
  input  logic [NCLIENTS-1:0]       i_m_rsd_rdy,
  output logic [DATA_W*NCLIENTS-1:0] o_m_rsd,
  output logic [NCLIENTS-1:0]       o_m_rsd_wr,
  vxe_axi_switch_mp_if.master       biu
);

  localparam int PTR_W = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  rqa_t              rqa_arr [NCLIENTS];
  rqd_t              rqd_arr [NCLIENTS];
  logic [NCLIENTS-1:0] outst_ok;
  logic [NCLIENTS-1:0] elig;
  logic [NCLIENTS-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_vld;
  logic [PTR_W-1:0]  rr;
  rqa_t              g_rqa;
  rqd_t              g_rqd;
  logic              g_wr;
  logic              g_rd;

  logic              aw_valid;
  logic [CID_W-1:0]  aw_cid;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] aw_data;
  logic [STRB_W-1:0] aw_strb;
  logic              ar_valid;
  logic [CID_W-1:0]  ar_cid;
  logic [ADDR_W-1:0] ar_addr;
  logic              aw_free;
  logic              ar_free;

  // A slot can take a new request when empty or being popped this cycle,
  // which sustains one grant per cycle into a continuously popped slot.
  assign aw_free = !aw_valid || biu.awpop;
  assign ar_free = !ar_valid || biu.arpop;

  always_comb begin
    elig = '0;
    for (int c = 0; c < NCLIENTS; c++) begin
      rqa_arr[c] = rqa_t'(i_m_rqa[c*RQA_W +: RQA_W]);
      rqd_arr[c] = rqd_t'(i_m_rqd[c*RQD_W +: RQD_W]);
      elig[c]    = !rst && i_m_rqa_vld[c] && outst_ok[c] &&
                   (rqa_arr[c].wr ? (i_m_rqd_vld[c] && aw_free) : ar_free);
    end
  end

  vxe_axi_switch_rr_arb #(
    .N     (NCLIENTS),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (elig),
    .rr        (rr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign g_rqa      = rqa_arr[grant_idx];
  assign g_rqd      = rqd_arr[grant_idx];
  assign g_wr       = grant_vld && g_rqa.wr;
  assign g_rd       = grant_vld && !g_rqa.wr;
  assign o_m_rqa_rd = grant;
  assign o_m_rqd_rd = g_rqa.wr ? grant : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      aw_valid <= 1'b0;
      aw_cid   <= '0;
      aw_addr  <= '0;
      aw_data  <= '0;
      aw_strb  <= '0;
      ar_valid <= 1'b0;
      ar_cid   <= '0;
      ar_addr  <= '0;
      rr       <= '0;
    end else begin
      if (g_wr) begin
        aw_valid <= 1'b1;
        aw_cid   <= {CLI_W'(grant_idx), g_rqa.txnid};
        aw_addr  <= g_rqa.addr;
        aw_data  <= g_rqd.data;
        aw_strb  <= g_rqd.strb;
      end else if (biu.awpop) begin
        aw_valid <= 1'b0;
      end

      if (g_rd) begin
        ar_valid <= 1'b1;
        ar_cid   <= {CLI_W'(grant_idx), g_rqa.txnid};
        ar_addr  <= g_rqa.addr;
      end else if (biu.arpop) begin
        ar_valid <= 1'b0;
      end

      if (grant_vld) begin
        rr <= (grant_idx == PTR_W'(NCLIENTS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign biu.awvalid = aw_valid;
  assign biu.awcid   = aw_cid;
  assign biu.awaddr  = aw_addr;
  assign biu.awdata  = aw_data;
  assign biu.awstrb  = aw_strb;
  assign biu.arvalid = ar_valid;
  assign biu.arcid   = ar_cid;
  assign biu.araddr  = ar_addr;

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  logic              b_valid;
  logic [CID_W-1:0]  b_cid;
  logic [1:0]        b_resp;
  logic              r_valid;
  logic [CID_W-1:0]  r_cid;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_data;
  logic              prio_r;
  logic [CLI_W-1:0]  b_cli;
  logic [CLI_W-1:0]  r_cli;
  logic [NCLIENTS-1:0] b_hit;
  logic [NCLIENTS-1:0] r_hit;
  logic [NCLIENTS-1:0] b_del;
  logic [NCLIENTS-1:0] r_del;
  logic              contested;
  logic              b_drop;
  logic              r_drop;
  logic              b_take;
  logic              r_take;

  assign b_cli = b_cid[CID_CLI_LSB +: CLI_W];
  assign r_cli = r_cid[CID_CLI_LSB +: CLI_W];

  // An out-of-range client index matches no hit bit; the slot is simply
  // emptied on the following edge.
  assign b_drop = b_valid && (int'(b_cli) >= NCLIENTS);
  assign r_drop = r_valid && (int'(r_cli) >= NCLIENTS);

  always_comb begin
    b_hit = '0;
    r_hit = '0;
    for (int k = 0; k < NCLIENTS; k++) begin
      b_hit[k] = b_valid && (b_cli == CLI_W'(k)) && i_m_rss_rdy[k];
      r_hit[k] = r_valid && (r_cli == CLI_W'(k)) && i_m_rss_rdy[k] && i_m_rsd_rdy[k];
    end
  end

  // Each slot hits at most one client, so any overlap means both slots want
  // the same client's status port this cycle.
  assign contested = |(b_hit & r_hit);
  assign b_del     = (rst || (contested && prio_r))  ? '0 : b_hit;
  assign r_del     = (rst || (contested && !prio_r)) ? '0 : r_hit;

  // Ready excludes drops, so a dropped response holds ready low for one cycle.
  assign b_take      = !b_valid || (|b_del);
  assign r_take      = !r_valid || (|r_del);
  assign biu.bready  = rst || b_take;
  assign biu.rready  = rst || r_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_cid   <= '0;
      b_resp  <= '0;
      r_valid <= 1'b0;
      r_cid   <= '0;
      r_resp  <= '0;
      r_data  <= '0;
      prio_r  <= 1'b1;
    end else begin
      if (biu.bpush && b_take) begin
        b_valid <= 1'b1;
        b_cid   <= biu.bcid;
        b_resp  <= biu.bresp;
      end else if ((|b_del) || b_drop) begin
        b_valid <= 1'b0;
      end

      if (biu.rpush && r_take) begin
        r_valid <= 1'b1;
        r_cid   <= biu.rcid;
        r_resp  <= biu.rresp;
        r_data  <= biu.rdata;
      end else if ((|r_del) || r_drop) begin
        r_valid <= 1'b0;
      end

      if (contested) prio_r <= !prio_r;
    end
  end

  always_comb begin
    o_m_rss = '0;
    o_m_rsd = '0;
    for (int k = 0; k < NCLIENTS; k++) begin
      if (b_del[k]) begin
        o_m_rss[k*RSS_W +: RSS_W] = make_rss(1'b1, b_resp, b_cid[CID_TXN_LSB +: TXN_W]);
      end else if (r_del[k]) begin
        o_m_rss[k*RSS_W +: RSS_W] = make_rss(1'b0, r_resp, r_cid[CID_TXN_LSB +: TXN_W]);
      end
      if (r_del[k]) o_m_rsd[k*DATA_W +: DATA_W] = r_data;
    end
  end

  assign o_m_rss_wr = b_del | r_del;
  assign o_m_rsd_wr = r_del;

  // ---------------------------------------------------------------------------
  // Outstanding-transaction limit
  // ---------------------------------------------------------------------------
`ifdef VXE_AXI_SWITCH_OUTST_LIMIT_EN
  logic [3:0]          outst [NCLIENTS];
  logic [NCLIENTS-1:0] dec;

  assign dec = b_del | r_del;

  always_comb begin
    outst_ok = '0;
    for (int c = 0; c < NCLIENTS; c++) begin
      outst_ok[c] = outst[c] < 4'(MAX_OUTST);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: this counter array must read zero after reset, so it is cleared
    // element by element; bulk data storage would be left unreset instead.
    if (rst) begin
      for (int c = 0; c < NCLIENTS; c++) outst[c] <= '0;
    end else begin
      for (int c = 0; c < NCLIENTS; c++) begin
        case ({grant[c], dec[c]})
          2'b10:   outst[c] <= outst[c] + 4'd1;
          2'b01:   if (outst[c] != '0) outst[c] <= outst[c] - 4'd1;
          default: ;
        endcase
      end
    end
  end
`else
  assign outst_ok = '1;
`endif

endmodule

// File: tb/tb_vxe_axi_switch_mp.sv
module tb_vxe_axi_switch_mp;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   i_m_rqa_vld, o_m_rqa_rd, i_m_rqd_vld, o_m_rqd_rd;
  logic [NC-1:0]   i_m_rss_rdy, o_m_rss_wr, i_m_rsd_rdy, o_m_rsd_wr;
  logic [44*NC-1:0] i_m_rqa;
  logic [72*NC-1:0] i_m_rqd;
  logic [9*NC-1:0]  o_m_rss;
  logic [64*NC-1:0] o_m_rsd;

  int n_checks = 0;
  int n_fail   = 0;

  vxe_axi_switch_mp_if biu_if ();

  vxe_axi_switch_mp #(.NCLIENTS(NC), .MAX_OUTST(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_m_rqa_vld (i_m_rqa_vld),
    .i_m_rqa     (i_m_rqa),
    .o_m_rqa_rd  (o_m_rqa_rd),
    .i_m_rqd_vld (i_m_rqd_vld),
    .i_m_rqd     (i_m_rqd),
    .o_m_rqd_rd  (o_m_rqd_rd),
    .i_m_rss_rdy (i_m_rss_rdy),
    .o_m_rss     (o_m_rss),
    .o_m_rss_wr  (o_m_rss_wr),
    .i_m_rsd_rdy (i_m_rsd_rdy),
    .o_m_rsd     (o_m_rsd),
    .o_m_rsd_wr  (o_m_rsd_wr),
    .biu         (biu_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_rqa(input int c, input logic wr, input logic [2:0] txn, input logic [39:0] addr);
    i_m_rqa[c*44 +: 44] = {wr, txn, addr};
  endtask

  task automatic set_rqd(input int c, input logic [7:0] strb, input logic [63:0] data);
    i_m_rqd[c*72 +: 72] = {strb, data};
  endtask

  task automatic push_r(input logic [5:0] cid, input logic [1:0] resp, input logic [63:0] data);
    biu_if.rpush = 1'b1;
    biu_if.rcid  = cid;
    biu_if.rresp = resp;
    biu_if.rdata = data;
  endtask

  initial begin
    rst         = 1'b1;
    i_m_rqa_vld = '0;
    i_m_rqd_vld = '0;
    i_m_rqa     = '0;
    i_m_rqd     = '0;
    i_m_rss_rdy = '1;
    i_m_rsd_rdy = '1;
    biu_if.awpop = 1'b0;
    biu_if.arpop = 1'b0;
    biu_if.bpush = 1'b0;
    biu_if.bcid  = '0;
    biu_if.bresp = '0;
    biu_if.rpush = 1'b0;
    biu_if.rcid  = '0;
    biu_if.rresp = '0;
    biu_if.rdata = '0;

    // Reset state
    next_cycle();
    mid();
    check("rst_awvalid", biu_if.awvalid, 0);
    check("rst_arvalid", biu_if.arvalid, 0);
    check("rst_bready",  biu_if.bready, 1);
    check("rst_rready",  biu_if.rready, 1);
    check("rst_rss_wr",  o_m_rss_wr, 0);
    check("rst_rqa_rd",  o_m_rqa_rd, 0);
    check("rst_rss",     o_m_rss, 0);
    next_cycle();
    rst = 1'b0;

    // Clients 0 and 2 stream reads with arpop held high
    next_cycle();
    set_rqa(0, 1'b0, 3'd1, 40'h100);
    set_rqa(2, 1'b0, 3'd5, 40'h200);
    i_m_rqa_vld  = 4'b0101;
    biu_if.arpop = 1'b1;
    mid();
    check("rr_g1", o_m_rqa_rd, 4'b0001);
    next_cycle(); mid();
    check("rr_g2", o_m_rqa_rd, 4'b0100);
    check("rr_cid1", biu_if.arcid, 6'h01);
    check("rr_addr1", biu_if.araddr, 40'h100);
    next_cycle(); mid();
    check("rr_g3", o_m_rqa_rd, 4'b0001);
    check("rr_cid2", biu_if.arcid, 6'h15);
    next_cycle(); mid();
    check("rr_g4", o_m_rqa_rd, 4'b0100);
    check("rr_cid3", biu_if.arcid, 6'h01);
    next_cycle();
    i_m_rqa_vld = '0;
    mid();
    check("rr_cid4", biu_if.arcid, 6'h15);
    check("rr_arvalid4", biu_if.arvalid, 1);
    check("rr_idle_rd", o_m_rqa_rd, 0);
    next_cycle(); mid();
    check("ar_pop_clear", biu_if.arvalid, 0);

    // Return the four reads back to back
    next_cycle();
    push_r(6'h01, 2'b00, 64'hA0);
    next_cycle();
    push_r(6'h15, 2'b10, 64'hA2);
    mid();
    check("r1_rsd_wr", o_m_rsd_wr, 4'b0001);
    check("r1_rss_wr", o_m_rss_wr, 4'b0001);
    check("r1_rss",    o_m_rss[8:0], 9'h001);
    check("r1_rsd",    o_m_rsd[63:0], 64'hA0);
    check("r1_rready", biu_if.rready, 1);
    next_cycle();
    push_r(6'h01, 2'b00, 64'hA1);
    mid();
    check("r2_rsd_wr", o_m_rsd_wr, 4'b0100);
    check("r2_rss",    o_m_rss[18 +: 9], 9'h085);
    check("r2_rsd",    o_m_rsd[128 +: 64], 64'hA2);
    next_cycle();
    push_r(6'h15, 2'b00, 64'hA3);
    mid();
    check("r3_rsd_wr", o_m_rsd_wr, 4'b0001);
    next_cycle();
    biu_if.rpush = 1'b0;
    mid();
    check("r4_rsd_wr", o_m_rsd_wr, 4'b0100);
    next_cycle(); mid();
    check("r5_idle", o_m_rsd_wr, 0);

    // Client 1 write waits for its data
    next_cycle();
    set_rqa(1, 1'b1, 3'd3, 40'h12_3456_7890);
    set_rqd(1, 8'hF0, 64'h1111_2222_3333_4444);
    i_m_rqa_vld  = 4'b0010;
    biu_if.awpop = 1'b1;
    mid();
    check("w_wait1", o_m_rqa_rd, 0);
    check("w_wait1d", o_m_rqd_rd, 0);
    next_cycle(); mid();
    check("w_wait2", o_m_rqa_rd, 0);
    next_cycle(); mid();
    check("w_wait3", o_m_rqa_rd, 0);
    next_cycle();
    i_m_rqd_vld = 4'b0010;
    mid();
    check("w_grant_rqa", o_m_rqa_rd, 4'b0010);
    check("w_grant_rqd", o_m_rqd_rd, 4'b0010);
    next_cycle();
    i_m_rqa_vld = '0;
    i_m_rqd_vld = '0;
    mid();
    check("w_awvalid", biu_if.awvalid, 1);
    check("w_awcid",   biu_if.awcid, 6'h0B);
    check("w_awaddr",  biu_if.awaddr, 40'h12_3456_7890);
    check("w_awdata",  biu_if.awdata, 64'h1111_2222_3333_4444);
    check("w_awstrb",  biu_if.awstrb, 8'hF0);
    check("w_once_rqa", o_m_rqa_rd, 0);
    check("w_once_rqd", o_m_rqd_rd, 0);
    next_cycle(); mid();
    check("w_pop_clear", biu_if.awvalid, 0);

    // Client 0 outstanding limit (MAX_OUTST = 2)
    next_cycle();
    set_rqa(0, 1'b0, 3'd2, 40'h300);
    i_m_rqa_vld = 4'b0001;
    mid();
    check("lim_g1", o_m_rqa_rd, 4'b0001);
    next_cycle(); mid();
    check("lim_g2", o_m_rqa_rd, 4'b0001);
`ifdef VXE_AXI_SWITCH_OUTST_LIMIT_EN
    next_cycle(); mid();
    check("lim_held1", o_m_rqa_rd, 0);
    next_cycle();
    push_r(6'h02, 2'b00, 64'hB0);
    mid();
    check("lim_held2", o_m_rqa_rd, 0);
    next_cycle();
    biu_if.rpush = 1'b0;
    mid();
    check("lim_resp", o_m_rsd_wr, 4'b0001);
    check("lim_held3", o_m_rqa_rd, 0);
    next_cycle(); mid();
    check("lim_g3", o_m_rqa_rd, 4'b0001);
`else
    next_cycle(); mid();
    check("nolim_g3", o_m_rqa_rd, 4'b0001);
`endif
    next_cycle();
    i_m_rqa_vld = '0;
    mid();
    check("lim_arvalid", biu_if.arvalid, 1);
    check("lim_arcid",   biu_if.arcid, 6'h02);

    // Same-cycle B and R for client 3: R first
    next_cycle();
    biu_if.bpush = 1'b1;
    biu_if.bcid  = 6'h1A;
    biu_if.bresp = 2'b00;
    push_r(6'h1C, 2'b00, 64'hC3C3_0000_1234_5678);
    next_cycle();
    biu_if.bpush = 1'b0;
    biu_if.rpush = 1'b0;
    mid();
    check("br_r_rsd_wr", o_m_rsd_wr, 4'b1000);
    check("br_r_rss_wr", o_m_rss_wr, 4'b1000);
    check("br_r_rss",    o_m_rss[27 +: 9], 9'h004);
    check("br_r_rsd",    o_m_rsd[192 +: 64], 64'hC3C3_0000_1234_5678);
    check("br_bready_lo", biu_if.bready, 0);
    check("br_rready_hi", biu_if.rready, 1);
    next_cycle(); mid();
    check("br_b_rss_wr", o_m_rss_wr, 4'b1000);
    check("br_b_rsd_wr", o_m_rsd_wr, 0);
    check("br_b_rss",    o_m_rss[27 +: 9], 9'h102);
    check("br_bready_hi", biu_if.bready, 1);

    // R response naming client 7 is dropped
    next_cycle();
    push_r(6'h38, 2'b00, 64'hDD);
    next_cycle();
    biu_if.rpush = 1'b0;
    mid();
    check("drop_rss_wr", o_m_rss_wr, 0);
    check("drop_rsd_wr", o_m_rsd_wr, 0);
    check("drop_rready_lo", biu_if.rready, 0);
    next_cycle(); mid();
    check("drop_rready_hi", biu_if.rready, 1);
    check("drop_rss_wr2", o_m_rss_wr, 0);

    // Reset with AW slot valid and client 0 holding two outstanding
    next_cycle();
    push_r(6'h00, 2'b00, 64'hE0);
    next_cycle();
    biu_if.rpush = 1'b0;
    mid();
    check("pre_rst_resp", o_m_rsd_wr, 4'b0001);
    next_cycle();
    set_rqa(0, 1'b1, 3'd6, 40'h400);
    set_rqd(0, 8'h0F, 64'h5555_6666_7777_8888);
    i_m_rqa_vld  = 4'b0001;
    i_m_rqd_vld  = 4'b0001;
    biu_if.awpop = 1'b0;
    mid();
    check("pre_rst_grant", o_m_rqa_rd, 4'b0001);
    next_cycle();
    i_m_rqa_vld = '0;
    i_m_rqd_vld = '0;
    mid();
    check("pre_rst_awvalid", biu_if.awvalid, 1);
    check("pre_rst_awcid",   biu_if.awcid, 6'h06);
`ifdef VXE_AXI_SWITCH_OUTST_LIMIT_EN
    check("pre_rst_outst", dut.outst[0], 4'd2);
`endif
    next_cycle();
    rst = 1'b1;
    mid();
    check("in_rst_bready", biu_if.bready, 1);
    check("in_rst_rready", biu_if.rready, 1);
    next_cycle();
    rst = 1'b0;
    mid();
    check("post_rst_awvalid", biu_if.awvalid, 0);
`ifdef VXE_AXI_SWITCH_OUTST_LIMIT_EN
    check("post_rst_outst", dut.outst[0], 4'd0);
`endif
    next_cycle();
    push_r(6'h06, 2'b00, 64'hF0);
    next_cycle();
    biu_if.rpush = 1'b0;
    mid();
    check("late_rsd_wr", o_m_rsd_wr, 4'b0001);
    check("late_rsd",    o_m_rsd[63:0], 64'hF0);
    next_cycle(); mid();
`ifdef VXE_AXI_SWITCH_OUTST_LIMIT_EN
    check("late_outst_floor", dut.outst[0], 4'd0);
`endif
    check("late_idle", o_m_rsd_wr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vxe_axi_switch_mp.md
# vxe_axi_switch_mp

Multi-client AXI switch between N memory-hub clients and the AXI interface unit (BIU). It generalises the single-client switch:
- round-robin arbitration of client requests onto the BIU write and read channels;
- client index encoded in the transaction ID;
- per-client outstanding limits;
- responses routed back to the owning client's response ports.

## Interface
Parameters:
- NCLIENTS, 4: number of clients, 1..8.
- MAX_OUTST, 8: maximum in-flight transactions per client, 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_m_rqa_vld  in  NCLIENTS  per-client request-address valid
- i_m_rqa  in  44*NCLIENTS  per-client {wr[43], txnid[42:40], addr[39:0]}
- o_m_rqa_rd  out  NCLIENTS  request-address consumed
- i_m_rqd_vld  in  NCLIENTS  per-client write-data valid
- i_m_rqd  in  72*NCLIENTS  per-client {strb[71:64], data[63:0]}
- o_m_rqd_rd  out  NCLIENTS  write data consumed
- i_m_rss_rdy  in  NCLIENTS  client status FIFO not full
- o_m_rss  out  9*NCLIENTS  {wr[8], resp[7:6], 3'b000, txnid[2:0]}
- o_m_rss_wr  out  NCLIENTS  status write strobe
- i_m_rsd_rdy  in  NCLIENTS  client read-data FIFO not full
- o_m_rsd  out  64*NCLIENTS  read data
- o_m_rsd_wr  out  NCLIENTS  read-data write strobe
- biu_awcid/awaddr/awdata/awstrb/awvalid  out  6/40/64/8/1  write request; cid={client[2:0],txnid}
- biu_awpop  in  1  BIU consumed write request
- biu_arcid/araddr/arvalid  out  6/40/1  read request
- biu_arpop  in  1  BIU consumed read request
- biu_bcid/bresp/bpush  in  6/2/1  write response
- biu_bready  out  1  write-response slot available
- biu_rcid/rdata/rresp/rpush  in  6/64/2/1  read response
- biu_rready  out  1  read-response slot available

## Operation
- Eligibility of client c, all required:
  - i_m_rqa_vld[c];
  - for writes, i_m_rqd_vld[c] also set;
  - outst[c] < MAX_OUTST;
  - target slot (AW or AR) free, where free = !valid || pop.
- Arbitration: one grant per cycle, round-robin. Search starts at pointer rr; after a grant, rr = grant+1 mod NCLIENTS.
- Grant actions:
  - pulse o_m_rqa_rd[c], and o_m_rqd_rd[c] for writes;
  - load the AW or AR slot next cycle;
  - outst[c]++.
- Slot is held stable until the pop. On pop with no same-cycle refill, valid clears.
- Response path: B slot and R slot are one-entry registers. biu_bready = !b_valid || b_deliver; biu_rready likewise with R.
- Delivery from B slot to client k=bcid[5:3]:
  - o_m_rss_wr[k] when i_m_rss_rdy[k].
- Delivery from R slot to client k:
  - o_m_rss_wr[k] and o_m_rsd_wr[k] together, only when both rdy bits are set.
- B and R slots targeting the same client in the same cycle: one delivers. A toggle bit alternates priority on each contested cycle; it starts at R.
- Delivery decrements outst[k]. Increment and decrement in the same cycle leave it unchanged. Decrement at 0 holds 0.
- Response with client index >= NCLIENTS: dropped. The slot clears in the following cycle, with no client strobe and no counter change.

## Timing
- Reset values:
  - all slots invalid;
  - all o_* strobes, biu_awvalid and biu_arvalid at 0;
  - data outputs at 0;
  - outst and rr at 0;
  - priority toggle at R.
- biu_bready and biu_rready read 1 during reset.
- Request latency: grant cycle t → biu_*valid at t+1. Back-to-back grants into the same slot are sustained when pop happens every cycle.
- Response latency: push at t → client strobe at t+1 if the client is ready. Full throughput of 1 response per cycle per channel.
- Reset mid-operation: all in-flight state is discarded. Responses arriving after reset are delivered normally; counters floor at 0.

## Configuration
- VXE_AXI_SWITCH_OUTST_LIMIT_EN:
  - Defined: per-client counters exist and gate eligibility as above.
  - Undefined: counters are removed, eligibility ignores outstanding count, and MAX_OUTST is unused.

## Structure
- Package vxe_axi_switch_pkg holds:
  - field offsets and widths of rqa/rqd/rss/cid;
  - the RESP_OKAY/RESP_SLVERR constants;
  - the client-index width constant (3).
- Sub-module vxe_axi_switch_rr_arb: parametrised NCLIENTS round-robin arbiter (req vector, rr pointer → one-hot grant).

## Test plan
- Clients 0 and 2 continuously request reads, pop held at 1: grants alternate 0,2,0,2; arcid[5:3] follows 0,2.
- Client 1 write with rqa_vld=1 and rqd_vld=0 for 3 cycles, then rqd_vld=1: no grant until rqd_vld. Then awvalid next cycle with awcid={3'd1,txnid}, and rqa_rd/rqd_rd both pulse once.
- MAX_OUTST=2, client 0 issues 3 reads with no responses: third request is held. After one R response is delivered, the third request is granted the following cycle.
- B and R responses for client 3 pushed in the same cycle: R delivered first, B the next cycle. bready stays low while B waits.
- rcid[5:3]=7 with NCLIENTS=4: no client strobe, and rready returns to 1 after one cycle.
- rst asserted with AW slot valid and outst[0]=2: next cycle awvalid=0 and outst[0]=0. A late response does not underflow the counter.
